mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_LIMIT, default 32'h0001_0000, first byte address outside the data memory.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 a_req  input  1  port A (instruction fetch, read-only) request; held high until a_ack.
REQ-005 a_addr  input  32  port A byte address.
REQ-006 a_ack  output  1  port A one-cycle completion pulse.
REQ-007 a_rdata  output  32  port A read data; valid when a_ack=1, held until the next A completion.
REQ-008 a_err  output  1  port A error flag; valid with a_ack.
REQ-009 b_req  input  1  port B (load/store) request; held high until b_ack.
REQ-010 b_we  input  1  port B write when 1, read when 0.
REQ-011 b_addr  input  32  port B byte address.
REQ-012 b_wdata  input  32  port B write data.
REQ-013 b_ack, b_rdata, b_err  output  1/32/1  port B equivalents of REQ-006..008.
REQ-014 mem_write  output  1  data memory write strobe; the memory commits on posedge clk.
REQ-015 mem_read  output  1  data memory read enable.
REQ-016 mem_addr  output  32  data memory byte address.
REQ-017 mem_wdata  output  32  data memory write data, little-endian word.
REQ-018 mem_rdata  input  32  data memory combinational read data.

Function
REQ-019 The FSM SHALL have three states: IDLE, ACCESS, ACK. There is one owner register (A or B) and one last_grant register.
- IDLE, no request -> IDLE.
- IDLE, any request -> ACCESS.
- ACCESS -> ACK unconditionally.
- ACK -> IDLE unconditionally.
REQ-020 Arbitration SHALL occur in IDLE only:
- single requester wins;
- both requesting: the port not equal to last_grant wins;
- after reset, last_grant=A, so B wins the first tie.
REQ-021 The owner and its request fields SHALL be latched on the IDLE->ACCESS edge. Requester inputs SHALL be ignored outside IDLE.
REQ-022 In ACCESS, mem_addr SHALL equal the latched address.
- mem_read=1 for an A access or a B read.
- mem_write=1 only for a B write.
- Strobes SHALL be decoded from the state and are 0 in every other state.
REQ-023 On the ACCESS->ACK edge, a read SHALL capture mem_rdata into the owner's rdata register.
REQ-024 In ACK, only the owner's ack SHALL be 1, for exactly one cycle. last_grant SHALL be updated to the owner on that edge.
REQ-025 Latency SHALL be: request seen in IDLE at cycle n -> memory access at n+1 -> ack at n+2. Back-to-back service SHALL be one access per 3 cycles.
REQ-026 A requester holding req high through its ack SHALL be re-arbitrated in the following IDLE cycle as a new request.
REQ-027 Error condition: latched address[1:0]!=0, or address > ADDR_LIMIT-4.
- The access SHALL still pass ACCESS and ACK with both strobes 0.
- err=1 with ack.
- rdata SHALL be left unchanged.
REQ-028 err SHALL be 0 in every cycle where the matching ack=0.
REQ-029 mem_wdata SHALL equal the latched b_wdata during a B write ACCESS. It is don't-care otherwise.
REQ-030 Alternation: with both ports requesting continuously, grants SHALL alternate B, A, B, A, ... and neither port waits more than one other access.

Reset
REQ-031 When rst=1 at posedge clk, the block SHALL enter IDLE with:
- last_grant=A;
- a_rdata, b_rdata = 0;
- all acks, errs and strobes 0 from the following cycle.
REQ-032 Reset SHALL dominate every transition. A B write whose ACCESS cycle coincides with rst=1 still commits at that edge; no ack SHALL be issued for it.
REQ-033 A request pending during reset SHALL be re-arbitrated from IDLE once rst deasserts.

Verification
REQ-034 Reset then a_req, a_addr=0x10, memory word 0x11223344 -> mem_read=1 at cycle 1, a_ack=1 at cycle 2, a_rdata=0x11223344, a_err=0.
REQ-035 b_req, b_we=1, b_addr=0x20, b_wdata=0xDEADBEEF; then B read 0x20 -> mem_write for exactly one cycle; the read returns 0xDEADBEEF.
REQ-036 a_req and b_req held high for 4 accesses after reset -> ack order B, A, B, A; 3 cycles per access.
REQ-037 B read at 0x22, then A read at 0xFFFE -> each completes with err=1 and no strobe; rdata unchanged.
REQ-038 rst pulsed during the ACCESS cycle of a B write to 0x40 -> no b_ack; FSM in IDLE next cycle; a later read of 0x40 returns the written data.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one data memory: port A fetches, port B loads/stores.
// Three-state FSM (IDLE/ACCESS/ACK) with alternating priority on ties.
module mem_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic [31:0] a_addr,
  output logic        a_ack,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_e;
  typedef enum logic {PORT_A, PORT_B} port_e;

  localparam logic [31:0] LAST_WORD = ADDR_LIMIT - 32'd4;

  state_e      state_q;
  port_e       owner_q, last_grant_q, grant_d;
  logic [31:0] addr_q, wdata_q, addr_d;
  logic        we_q, err_q, err_d;
  logic [31:0] a_rdata_q, b_rdata_q;

  // Tie goes to whichever port was not served last.
  always_comb begin
    grant_d = PORT_A;
    if (a_req && b_req) grant_d = (last_grant_q == PORT_A) ? PORT_B : PORT_A;
    else if (b_req)     grant_d = PORT_B;
    addr_d = (grant_d == PORT_B) ? b_addr : a_addr;
    err_d  = (addr_d[1:0] != 2'b00) || (addr_d > LAST_WORD);
  end

  // NOTE: only control state and the architecturally visible rdata registers are
  // reset; the latched request fields are always written before they are used.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_A;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (a_req || b_req) begin
            state_q <= ACCESS;
            owner_q <= grant_d;
            addr_q  <= addr_d;
            we_q    <= (grant_d == PORT_B) && b_we;
            wdata_q <= b_wdata;
            err_q   <= err_d;
          end
        end
        ACCESS: begin
          state_q <= ACK;
          if (!err_q && !we_q) begin
            if (owner_q == PORT_A) a_rdata_q <= mem_rdata;
            else                   b_rdata_q <= mem_rdata;
          end
        end
        ACK: begin
          state_q      <= IDLE;
          last_grant_q <= owner_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes and acks decode directly from registered state, so they are glitch-free.
  assign mem_read  = (state_q == ACCESS) && !err_q && !we_q;
  assign mem_write = (state_q == ACCESS) && !err_q && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign a_ack   = (state_q == ACK) && (owner_q == PORT_A);
  assign b_ack   = (state_q == ACK) && (owner_q == PORT_B);
  assign a_err   = a_ack && err_q;
  assign b_err   = b_ack && err_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of grants, errors and memory contents.
module tb_mem_arbiter;

  localparam logic [31:0] LIMIT = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [31:0] a_addr = '0, b_addr = '0, b_wdata = '0;
  logic        a_ack, a_err, b_ack, b_err, mem_write, mem_read;
  logic [31:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.ADDR_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Physical memory driven only by the DUT strobes.
  logic [31:0] phys_mem [0:16383];
  assign mem_rdata = phys_mem[mem_addr[15:2]];
  always @(posedge clk) if (mem_write) phys_mem[mem_addr[15:2]] <= mem_wdata;

  // Reference model state.
  logic [31:0] ref_mem [0:16383];
  logic [31:0] exp_a, exp_b;
  int          last_m;  // 0 = A served last, 1 = B
  int          errors = 0, checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access, entered at a negedge while the DUT is idle with requests driven.
  task automatic serve(input bit hold);
    int          w;
    logic [31:0] addr, wd;
    logic        we, err;
    if (a_req && b_req) w = (last_m == 0) ? 1 : 0;
    else                w = b_req ? 1 : 0;
    addr = (w == 1) ? b_addr : a_addr;
    we   = (w == 1) && b_we;
    wd   = b_wdata;
    err  = (addr[1:0] != 2'b00) || (addr > LIMIT - 32'd4);

    check("idle_outputs", 32'({a_ack, b_ack, mem_read, mem_write}), 32'd0);
    @(posedge clk); @(negedge clk);
    check("access_read",  32'(mem_read),  32'(!err && !we));
    check("access_write", 32'(mem_write), 32'(!err && we));
    check("access_ack",   32'({a_ack, b_ack}), 32'd0);
    if (!err) check("access_addr", mem_addr, addr);
    if (!err && we) check("access_wdata", mem_wdata, wd);
    if (!err) begin
      if (we)          ref_mem[addr[15:2]] = wd;
      else if (w == 1) exp_b = ref_mem[addr[15:2]];
      else             exp_a = ref_mem[addr[15:2]];
    end
    @(posedge clk); @(negedge clk);
    check("ack",        32'({a_ack, b_ack}), (w == 1) ? 32'd1 : 32'd2);
    check("err",        32'({a_err, b_err}), err ? ((w == 1) ? 32'd1 : 32'd2) : 32'd0);
    check("ack_strobe", 32'({mem_read, mem_write}), 32'd0);
    check("a_rdata", a_rdata, exp_a);
    check("b_rdata", b_rdata, exp_b);
    last_m = w;
    if (!hold) begin
      if (w == 1) b_req = 1'b0;
      else        a_req = 1'b0;
    end
    @(posedge clk); @(negedge clk);
  endtask

  // Reset leaves requests untouched so pending ones are re-arbitrated afterwards.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_m = 0; exp_a = '0; exp_b = '0;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] r;
    case ($urandom_range(0, 7))
      0:       r = {16'h0, $urandom_range(0, 16383) == 0 ? 14'd0 : 14'($urandom_range(0, 16383)), 2'($urandom_range(1, 3))};
      1:       r = 32'h0000_FFFC;
      2:       r = 32'h0001_0000 + {$urandom_range(0, 255), 2'b00};
      default: r = {16'h0, 14'($urandom_range(0, 63)), 2'b00};
    endcase
    return r;
  endfunction

  initial begin
    logic [31:0] wd;
    for (int i = 0; i < 16384; i++) begin
      phys_mem[i] = 32'(i) * 32'h9E37_79B9 ^ 32'h0000_1234;
      ref_mem[i]  = phys_mem[i];
    end
    phys_mem[4] = 32'h1122_3344;
    ref_mem[4]  = 32'h1122_3344;

    // Reset state, with an A fetch already pending.
    a_req = 1'b1; a_addr = 32'h10;
    do_reset();
    check("rst_a_rdata", a_rdata, 32'd0);
    check("rst_b_rdata", b_rdata, 32'd0);
    check("rst_acks_errs", 32'({a_ack, b_ack, a_err, b_err}), 32'd0);
    serve(1'b0);

    // Store then load back.
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h20; b_wdata = 32'hDEAD_BEEF;
    serve(1'b0);
    b_req = 1'b1; b_we = 1'b0;
    serve(1'b0);
    check("readback_20", b_rdata, 32'hDEAD_BEEF);

    // Continuous contention after reset: B, A, B, A at 3 cycles each.
    do_reset();
    a_req = 1'b1; a_addr = 32'h10;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h24;
    for (int k = 0; k < 4; k++) begin
      serve(1'b1);
      check("alternation", 32'(last_m), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    a_req = 1'b0; b_req = 1'b0;
    @(posedge clk); @(negedge clk);

    // Misaligned B read, then misaligned A fetch near the top of memory.
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h22;
    serve(1'b0);
    a_req = 1'b1; a_addr = 32'h0000_FFFE;
    serve(1'b0);
    a_req = 1'b1; a_addr = 32'h0000_FFFC;
    serve(1'b0);
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h0001_0000; b_wdata = 32'hBAD0_BAD0;
    serve(1'b0);

    // Reset during the ACCESS cycle of a store: write commits, no ack.
    wd = $urandom;
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h40; b_wdata = wd;
    @(posedge clk); @(negedge clk);
    check("rst_store_write", 32'(mem_write), 32'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; b_req = 1'b0;
    check("rst_store_noack", 32'({a_ack, b_ack, mem_read, mem_write}), 32'd0);
    check("rst_store_rdata", b_rdata, 32'd0);
    ref_mem[16] = wd; last_m = 0; exp_a = '0; exp_b = '0;
    @(posedge clk); @(negedge clk);
    check("rst_store_idle", 32'({a_ack, b_ack, mem_read, mem_write}), 32'd0);
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h40;
    serve(1'b0);
    check("readback_40", b_rdata, wd);

    // Random mixed traffic.
    for (int n = 0; n < 80; n++) begin
      int sel;
      sel     = $urandom_range(1, 3);
      a_req   = sel[0];
      b_req   = sel[1];
      a_addr  = pick_addr();
      b_addr  = pick_addr();
      b_we    = 1'($urandom_range(0, 1));
      b_wdata = $urandom;
      while (a_req || b_req) serve(1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
